intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- 8-source interrupt controller between peripheral request lines and a processor.
- Configured after reset over a shared 8-bit bidirectional bus into one of two modes: round-robin polling, or a programmable 8-entry priority order.
- Raises one interrupt at a time, places a vector on the bus when acknowledged, and waits for an end-of-interrupt (EOI) message before servicing the next request.

Parameters:
- POLL_ADDR_PFX, 5'b01011, vector prefix driven in polling mode
- PRIO_ADDR_PFX, 5'b10011, vector prefix driven in priority mode
- POLL_EOI_PFX, 5'b10100, EOI prefix expected in polling mode
- PRIO_EOI_PFX, 5'b01100, EOI prefix expected in priority mode

Ports:
- clk  in  1  clock, rising edge
- rst_in  in  1  asynchronous, active-high reset
- intr_rq  in  8  level interrupt requests, bit n = source n
- intr_bus  inout  8  shared bus; driven by the block only while bus_oe=1, otherwise high-Z
- intr_in  in  1  active-low acknowledge/strobe from the processor
- intr_out  out  1  interrupt to the processor, active high
- bus_oe  out  1  high while the block drives intr_bus

Behaviour:
- Interface: one clock (clk); reset rst_in is asynchronous and active-high.
- Reset values: intr_out=0, bus_oe=0, intr_bus=Z, state=CFG, mode=none, poll pointer=0, config count=0, priority table=identity (0..7).
- Strobe: an "ack" is intr_in sampled 0 at a rising edge when it was 1 at the previous edge. Holding intr_in low counts once.
- States: CFG, IDLE, INT, ADDR, EOI.
- CFG, bus[1:0]=01: mode=POLL, go to IDLE.
- CFG, bus[1:0]=10: table[2k]=bus[7:5], table[2k+1]=bus[4:2], k=k+1, one write per clock. After the 4th write (k=3): mode=PRIO, go to IDLE.
- CFG, bus[1:0]=00 or 11: ignored. A 01 with partial table writes discards them and selects POLL.
- Bus contents are never interpreted as configuration outside CFG.
- IDLE/POLL: if intr_rq[ptr]=1, latch id=ptr; otherwise ptr=ptr+1 (mod 8) each clock.
- IDLE/PRIO: latch id = first table entry whose request is set, evaluated in one cycle.
- On a latch: go to INT; intr_out=1 from the next edge. Requests changing after the latch do not preempt.
- INT: on ack, drive intr_bus={pfx_addr,id}, bus_oe=1, intr_out=0; go to ADDR. Bus is valid from that same edge.
- ADDR: on ack, bus_oe=0; go to EOI.
- EOI: on ack with intr_bus={pfx_eoi,id}, go to IDLE. In POLL, ptr=id+1 (mod 8). Non-matching acks are ignored; the block stays in EOI.
- The block does not require intr_rq[id] to stay high after the latch.
- Duplicate table IDs are not checked. A source absent from the table is never serviced.
- No request pending in IDLE: stay in IDLE, intr_out=0.
- Reset mid-service: outputs return to reset values immediately; configuration is lost.

Optional Feature:
- INTR_CTRL_EOI_CHECK_EN defined: the EOI ack must carry a matching {pfx_eoi,id} on the bus, as above.
- Undefined: any ack in EOI completes the service and bus contents are ignored.

Test Plan:
- Reset, bus=8'h01, intr_rq=8'b1010_1010, processor clears each serviced bit -> vectors 8'b01011_001, 011, 101, 111 in order. Then intr_rq=8'b0101_0101 -> 01011_000, 010, 100, 110.
- Reset, bus writes 8'b101_011_10, 111_000_10, 100_010_10, 110_001_10 (last held 4 clocks), intr_rq=8'hFF -> services 5,3,7,0 with vectors {10011,id}.
- Priority run continued: set rq[3] after 4 is granted, set rq[5] after 2 is granted -> order 4,3,2,5,6,1. The newly raised requests must not preempt the already-latched id.
- Wrong EOI (e.g. {01100,3'd6} while servicing 3) with macro defined -> stays in EOI, intr_out stays 0. Correct EOI -> next interrupt raised.
- intr_in held low 5 cycles in INT -> exactly one transition (INT->ADDR); bus_oe stays 1.
- rst_in pulsed while in ADDR -> bus_oe=0, intr_out=0, intr_bus=Z immediately. The block re-enters CFG and raises no interrupt until reconfigured.

Source files
------------

// File: rtl/intr_ctrl.sv
// intr_ctrl: 8-source interrupt controller with round-robin polling or a
// programmable 8-entry priority order, configured over a shared 8-bit bus.
// Each service runs raise -> vector on ack -> release on ack -> EOI on ack.
// Optional build macro INTR_CTRL_EOI_CHECK_EN: when defined, the EOI ack must
// carry {eoi prefix, id} on the bus; when undefined, any ack in EOI completes.
// Handshake: the processor strobes intr_in low; one falling edge sampled on
// clk is one ack, however long the line is held low.
module intr_ctrl #(
    parameter logic [4:0] POLL_ADDR_PFX = 5'b01011,
    parameter logic [4:0] PRIO_ADDR_PFX = 5'b10011,
    parameter logic [4:0] POLL_EOI_PFX  = 5'b10100,
    parameter logic [4:0] PRIO_EOI_PFX  = 5'b01100
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic [7:0] intr_rq,
    inout  wire  [7:0] intr_bus,
    input  logic       intr_in,
    output logic       intr_out,
    output logic       bus_oe
);

    typedef enum logic [2:0] {S_CFG, S_IDLE, S_INT, S_ADDR, S_EOI} state_t;
    typedef enum logic [1:0] {M_NONE, M_POLL, M_PRIO} mode_t;

    // state is kept as a named enum so it can be probed hierarchically
    state_t     state;
    mode_t      mode;
    logic [2:0] ptr;
    logic [2:0] id;
    logic [1:0] cfg_cnt;
    logic [2:0] prio_tbl [8];
    logic [7:0] bus_q;
    logic       in_q;

    logic       ack;
    logic       prio_hit;
    logic [2:0] prio_id;
    logic [4:0] addr_pfx;
    logic [4:0] eoi_pfx;
    logic       eoi_match;
    logic       eoi_ok;

    assign ack       = in_q & ~intr_in;
    assign addr_pfx  = (mode == M_PRIO) ? PRIO_ADDR_PFX : POLL_ADDR_PFX;
    assign eoi_pfx   = (mode == M_PRIO) ? PRIO_EOI_PFX  : POLL_EOI_PFX;
    assign eoi_match = (intr_bus == {eoi_pfx, id});
    assign intr_bus  = bus_oe ? bus_q : 8'hzz;

`ifdef INTR_CTRL_EOI_CHECK_EN
    assign eoi_ok = eoi_match;
`else
    // Bus contents are ignored here; the match term stays so both builds share one datapath.
    assign eoi_ok = eoi_match | 1'b1;
`endif

    // Priority pick: scan the table from the last entry down so entry 0 wins.
    always_comb begin
        prio_hit = 1'b0;
        prio_id  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (intr_rq[prio_tbl[i]]) begin
                prio_hit = 1'b1;
                prio_id  = prio_tbl[i];
            end
        end
    end

    // Controller FSM: configuration, request latch, vector/release/EOI handshake.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state    <= S_CFG;
            mode     <= M_NONE;
            ptr      <= 3'd0;
            id       <= 3'd0;
            cfg_cnt  <= 2'd0;
            bus_q    <= 8'd0;
            bus_oe   <= 1'b0;
            intr_out <= 1'b0;
            in_q     <= 1'b1;
            for (int i = 0; i < 8; i++) prio_tbl[i] <= 3'(i);
        end else begin
            in_q <= intr_in;
            case (state)
                S_CFG: begin
                    case (intr_bus[1:0])
                        2'b01: begin
                            // Polling selected: any partial table load is discarded.
                            mode    <= M_POLL;
                            cfg_cnt <= 2'd0;
                            for (int i = 0; i < 8; i++) prio_tbl[i] <= 3'(i);
                            state   <= S_IDLE;
                        end
                        2'b10: begin
                            prio_tbl[{cfg_cnt, 1'b0}] <= intr_bus[7:5];
                            prio_tbl[{cfg_cnt, 1'b1}] <= intr_bus[4:2];
                            cfg_cnt <= cfg_cnt + 2'd1;
                            if (cfg_cnt == 2'd3) begin
                                mode  <= M_PRIO;
                                state <= S_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
                S_IDLE: begin
                    if (mode == M_POLL) begin
                        if (intr_rq[ptr]) begin
                            id       <= ptr;
                            intr_out <= 1'b1;
                            state    <= S_INT;
                        end else begin
                            ptr <= ptr + 3'd1;
                        end
                    end else if (mode == M_PRIO && prio_hit) begin
                        id       <= prio_id;
                        intr_out <= 1'b1;
                        state    <= S_INT;
                    end
                end
                S_INT: begin
                    if (ack) begin
                        bus_q    <= {addr_pfx, id};
                        bus_oe   <= 1'b1;
                        intr_out <= 1'b0;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (ack) begin
                        bus_oe <= 1'b0;
                        state  <= S_EOI;
                    end
                end
                S_EOI: begin
                    if (ack && eoi_ok) begin
                        if (mode == M_POLL) ptr <= id + 3'd1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_CFG;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed and randomized checks of intr_ctrl against a
// reference model that picks the next source by cyclic search (polling) or
// by walking the configured order (priority).
module tb_intr_ctrl;

    localparam logic [4:0] POLL_ADDR = 5'b01011;
    localparam logic [4:0] PRIO_ADDR = 5'b10011;
    localparam logic [4:0] POLL_EOI  = 5'b10100;
    localparam logic [4:0] PRIO_EOI  = 5'b01100;

    logic       clk = 1'b0;
    logic       rst_in;
    logic [7:0] rq;
    logic       intr_in;
    logic       intr_out;
    logic       bus_oe;
    logic [7:0] tb_bus;
    logic       tb_en;
    wire  [7:0] intr_bus;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         model_prio;
    int         model_ptr;
    logic [2:0] model_tbl [8];

    assign intr_bus = tb_en ? tb_bus : 8'hzz;

    intr_ctrl dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .intr_rq  (rq),
        .intr_bus (intr_bus),
        .intr_in  (intr_in),
        .intr_out (intr_out),
        .bus_oe   (bus_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Next source to be serviced, or -1 if none.
    function automatic int pick(input logic [7:0] r);
        if (!model_prio) begin
            for (int k = 0; k < 8; k++) if (r[(model_ptr + k) % 8]) return (model_ptr + k) % 8;
        end else begin
            for (int k = 0; k < 8; k++) if (r[model_tbl[k]]) return int'(model_tbl[k]);
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2 rst_in = 1'b1;
        #1;
        chk("rst_intr_out", {7'd0, intr_out}, 8'd0);
        chk("rst_bus_oe", {7'd0, bus_oe}, 8'd0);
        @(negedge clk);
        rst_in = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk) intr_in = 1'b0;
        @(negedge clk) intr_in = 1'b1;
    endtask

    task automatic send_eoi(input logic [7:0] v);
        @(negedge clk);
        tb_bus  = v;
        tb_en   = 1'b1;
        intr_in = 1'b0;
        @(negedge clk);
        intr_in = 1'b1;
        tb_en   = 1'b0;
    endtask

    task automatic cfg_poll();
        @(negedge clk);
        tb_bus = 8'h01;
        tb_en  = 1'b1;
        @(negedge clk) tb_en = 1'b0;
        model_prio = 1'b0;
        model_ptr  = 0;
    endtask

    task automatic cfg_prio(input int hold_last);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tb_bus = {model_tbl[2*k], model_tbl[2*k+1], 2'b10};
            tb_en  = 1'b1;
        end
        repeat (hold_last - 1) @(negedge clk);
        @(negedge clk) tb_en = 1'b0;
        model_prio = 1'b1;
    endtask

    task automatic wait_irq(output bit got);
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (intr_out === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One full service. set_mask is raised while the id is latched; keep_busy
    // guarantees another serviceable request before EOI.
    task automatic service(input logic [7:0] set_mask, input bit wrong_eoi,
                           input bit keep_busy, input int hold_len);
        int         exp_id;
        bit         got;
        logic [4:0] apfx;
        logic [4:0] epfx;
        exp_id = pick(rq);
        apfx   = model_prio ? PRIO_ADDR : POLL_ADDR;
        epfx   = model_prio ? PRIO_EOI : POLL_EOI;
        wait_irq(got);
        chk("irq_raise", {7'd0, got}, 8'd1);
        if (!got || exp_id < 0) return;
        chk("int_bus_oe", {7'd0, bus_oe}, 8'd0);
        rq = rq | set_mask;
        if (hold_len > 0) begin
            @(negedge clk) intr_in = 1'b0;
            for (int i = 0; i < hold_len; i++) begin
                @(negedge clk);
                chk("hold_bus_oe", {7'd0, bus_oe}, 8'd1);
            end
            intr_in = 1'b1;
        end else begin
            ack();
        end
        chk("vector", intr_bus, {apfx, 3'(exp_id)});
        chk("vec_bus_oe", {7'd0, bus_oe}, 8'd1);
        chk("vec_intr_out", {7'd0, intr_out}, 8'd0);
        rq[exp_id] = 1'b0;
        if (keep_busy && pick(rq) < 0) rq[model_tbl[$urandom_range(0, 7)]] = 1'b1;
        ack();
        chk("addr_bus_oe", {7'd0, bus_oe}, 8'd0);
        if (wrong_eoi) begin
            send_eoi({epfx, 3'((exp_id + 3) % 8)});
`ifdef INTR_CTRL_EOI_CHECK_EN
            repeat (4) @(negedge clk);
            chk("eoi_wrong_hold", {7'd0, intr_out}, 8'd0);
            send_eoi({epfx, 3'(exp_id)});
`endif
        end else begin
            send_eoi({epfx, 3'(exp_id)});
        end
        if (!model_prio) model_ptr = (exp_id + 1) % 8;
    endtask

    initial begin
        bit got;
        rst_in  = 1'b1;
        intr_in = 1'b1;
        rq      = 8'h00;
        tb_bus  = 8'h00;
        tb_en   = 1'b0;
        model_prio = 1'b0;
        model_ptr  = 0;
        for (int i = 0; i < 8; i++) model_tbl[i] = 3'(i);
        repeat (3) @(negedge clk);
        chk("init_intr_out", {7'd0, intr_out}, 8'd0);
        chk("init_bus_oe", {7'd0, bus_oe}, 8'd0);
        rst_in = 1'b0;

        // CFG ignores 00/11 and raises nothing; partial table then 01 selects polling
        rq = 8'hFF;
        @(negedge clk);
        tb_bus = 8'h00;
        tb_en  = 1'b1;
        @(negedge clk) tb_bus = 8'hFF;
        @(negedge clk) tb_bus = 8'b111_110_10;
        @(negedge clk) tb_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("cfg_no_irq", {7'd0, intr_out}, 8'd0);
        rq = 8'b1010_1010;
        cfg_poll();

        // polling: 1,3,5,7 then 0,2,4,6 (second set raised while 7 is latched)
        service(8'h00, 1'b0, 1'b0, 5);
        service(8'h00, 1'b0, 1'b0, 0);
        service(8'h00, 1'b0, 1'b0, 0);
        service(8'b0101_0101, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) service(8'h00, 1'b0, 1'b0, 0);
        repeat (10) @(negedge clk);
        chk("idle_no_irq", {7'd0, intr_out}, 8'd0);

        // priority order 5,3,7,0,4,2,6,1; last write held 4 clocks
        do_reset();
        model_tbl = '{3'd5, 3'd3, 3'd7, 3'd0, 3'd4, 3'd2, 3'd6, 3'd1};
        rq = 8'hFF;
        cfg_prio(4);
        for (int i = 0; i < 4; i++) service(8'h00, 1'b0, 1'b0, 0);
        service(8'b0000_1000, 1'b0, 1'b0, 0);
        service(8'h00, 1'b1, 1'b0, 0);
        service(8'b0010_0000, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) service(8'h00, 1'b0, 1'b0, 0);
        repeat (8) @(negedge clk);
        chk("prio_drained", {7'd0, intr_out}, 8'd0);

        // randomized priority table and requests
        do_reset();
        for (int i = 0; i < 8; i++) model_tbl[i] = 3'($urandom_range(0, 7));
        rq = 8'h00;
        rq[model_tbl[$urandom_range(0, 7)]] = 1'b1;
        rq = rq | 8'($urandom_range(0, 255));
        cfg_prio(1);
        for (int i = 0; i < 20; i++) service(8'($urandom_range(0, 255)), 1'b0, 1'b1, 0);

        // randomized polling
        do_reset();
        for (int i = 0; i < 8; i++) model_tbl[i] = 3'(i);
        rq = 8'($urandom_range(1, 255));
        cfg_poll();
        for (int i = 0; i < 20; i++) service(8'($urandom_range(0, 255)), 1'b0, 1'b1, 0);

        // reset while in ADDR: outputs drop at once, nothing raised until reconfigured
        wait_irq(got);
        chk("pre_rst_irq", {7'd0, got}, 8'd1);
        ack();
        chk("pre_rst_bus_oe", {7'd0, bus_oe}, 8'd1);
        #2 rst_in = 1'b1;
        #1;
        chk("midrst_bus_oe", {7'd0, bus_oe}, 8'd0);
        chk("midrst_intr_out", {7'd0, intr_out}, 8'd0);
        @(negedge clk) rst_in = 1'b0;
        rq = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {7'd0, intr_out}, 8'd0);
        end
        cfg_poll();
        service(8'h00, 1'b0, 1'b0, 0);
        service(8'h00, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
